// File: rtl/ddr3_test_pkg.sv
// ----------------------------------------------------------------------------
// ddr3_test_pkg
// Shared definitions for the DDR3 memory test blocks. The traffic generator
// writes the pattern and the read checker verifies it, so both take the base
// pattern and the checker state encoding from this one place.
//
// Contents:
//   check_state_e       - IDLE / CHECK / DONE states of the read checker
//   DATA_BASE_DEFAULT   - pattern for word 0; word i is DATA_BASE + i
//   pattern_word()      - reference helper returning the pattern for an index
// ----------------------------------------------------------------------------
package ddr3_test_pkg;

  // Read checker run states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } check_state_e;

  // Word 0 of the test pattern. Every following word is the previous one
  // plus one, computed mod 2^128.
  localparam logic [127:0] DATA_BASE_DEFAULT = 128'hdeadbeefabad1deaba53b411fadebabe;

  // Pattern value for an arbitrary word index. Intended for the generator
  // side and for reference use; the checker itself walks the pattern with
  // an incrementing register instead of this adder.
  function automatic logic [127:0] pattern_word(input logic [127:0] base,
                                                input logic [31:0]  index);
    return base + {96'd0, index};
  endfunction

endpackage : ddr3_test_pkg

// File: rtl/ddr3_read_checker.sv
// ----------------------------------------------------------------------------
// ddr3_read_checker
// Verifies a stream of DDR3 read data against the incrementing test pattern
// (word i = DATA_BASE + i). A run is started with a one-cycle start pulse,
// consumes exactly num_words words (one per rd_data_valid cycle), never stops
// early on errors, and then holds its results in DONE.
//
// Ports:
//   clk               in   UI clock shared with the DDR3 controller
//   reset             in   synchronous, active-high
//   start             in   one-cycle pulse; accepted in IDLE and DONE only
//   num_words  [31:0] in   word count of the run, latched on accepted start
//   rd_data   [127:0] in   controller read data
//   rd_data_valid     in   read data strobe (no backpressure)
//   busy              out  high while a run is in CHECK
//   done              out  level, high in DONE
//   pass              out  no mismatches in the run; valid while done
//   error_count [31:0]        out  mismatched words, saturating
//   first_error_index [31:0]  out  index of the first mismatch of the run
//   first_error_data [127:0]  out  data of the first mismatch of the run
//   cycles [63:0]             out  clock cycles spent in CHECK
// ----------------------------------------------------------------------------
module ddr3_read_checker
  import ddr3_test_pkg::*;
#(
  parameter logic [127:0] DATA_BASE = DATA_BASE_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [31:0]  num_words,
  input  logic [127:0] rd_data,
  input  logic         rd_data_valid,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [31:0]  error_count,
  output logic [31:0]  first_error_index,
  output logic [127:0] first_error_data,
  output logic [63:0]  cycles
);

  localparam logic [31:0] ERR_MAX = 32'hffffffff;

  check_state_e state_q, state_d;
  logic [31:0]  num_words_q, num_words_d;
  logic [31:0]  index_q, index_d;
  logic [127:0] expected_q, expected_d;
  logic [31:0]  error_count_q, error_count_d;
  logic [31:0]  first_error_index_q, first_error_index_d;
  logic [127:0] first_error_data_q, first_error_data_d;
  logic [63:0]  cycles_q, cycles_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         pass_q, pass_d;

  logic         consume;
  logic         mismatch;
  logic         last_word;

  // A word is only consumed while checking; valids in IDLE/DONE (including
  // one coinciding with an accepted start) fall through untouched.
  // expected_q already holds DATA_BASE + index_q, so the compare is a plain
  // equality against a register.
  always_comb begin
    consume   = (state_q == CHECK) && rd_data_valid;
    mismatch  = consume && (rd_data != expected_q);
    last_word = consume && (index_q == (num_words_q - 32'd1));
  end

  // Next-state and next-statistics logic. All outputs are computed here one
  // cycle ahead so that the flops drive them directly. The first-error
  // capture keys off error_count_q being zero: the count can only grow
  // within a run, so zero means no mismatch has been seen yet.
  always_comb begin
    state_d             = state_q;
    num_words_d         = num_words_q;
    index_d             = index_q;
    expected_d          = expected_q;
    error_count_d       = error_count_q;
    first_error_index_d = first_error_index_q;
    first_error_data_d  = first_error_data_q;
    cycles_d            = cycles_q;
    busy_d              = busy_q;
    done_d              = done_q;
    pass_d              = pass_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          num_words_d         = num_words;
          index_d             = 32'd0;
          expected_d          = DATA_BASE;
          error_count_d       = 32'd0;
          first_error_index_d = 32'd0;
          first_error_data_d  = 128'd0;
          cycles_d            = 64'd0;
          if (num_words == 32'd0) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end else begin
            state_d = CHECK;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            pass_d  = 1'b0;
          end
        end
      end

      CHECK: begin
        cycles_d = cycles_q + 64'd1;
        if (consume) begin
          index_d    = index_q + 32'd1;
          expected_d = expected_q + 128'd1;
          if (mismatch) begin
            if (error_count_q == 32'd0) begin
              first_error_index_d = index_q;
              first_error_data_d  = rd_data;
            end
            if (error_count_q != ERR_MAX) begin
              error_count_d = error_count_q + 32'd1;
            end
          end
          if (last_word) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (error_count_q == 32'd0) && !mismatch;
          end
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        pass_d  = 1'b0;
      end
    endcase
  end

  // State and statistics registers. Reset abandons any run in progress and
  // clears every reported value, so a reset mid-run never shows done/pass.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q             <= IDLE;
      num_words_q         <= 32'd0;
      index_q             <= 32'd0;
      expected_q          <= DATA_BASE;
      error_count_q       <= 32'd0;
      first_error_index_q <= 32'd0;
      first_error_data_q  <= 128'd0;
      cycles_q            <= 64'd0;
      busy_q              <= 1'b0;
      done_q              <= 1'b0;
      pass_q              <= 1'b0;
    end else begin
      state_q             <= state_d;
      num_words_q         <= num_words_d;
      index_q             <= index_d;
      expected_q          <= expected_d;
      error_count_q       <= error_count_d;
      first_error_index_q <= first_error_index_d;
      first_error_data_q  <= first_error_data_d;
      cycles_q            <= cycles_d;
      busy_q              <= busy_d;
      done_q              <= done_d;
      pass_q              <= pass_d;
    end
  end

  assign busy              = busy_q;
  assign done              = done_q;
  assign pass              = pass_q;
  assign error_count       = error_count_q;
  assign first_error_index = first_error_index_q;
  assign first_error_data  = first_error_data_q;
  assign cycles            = cycles_q;

endmodule : ddr3_read_checker

// File: tb/tb_ddr3_read_checker.sv
// ----------------------------------------------------------------------------
// tb_ddr3_read_checker
// Randomized self-checking bench for ddr3_read_checker. The reference model
// simply knows that word i must equal BASE + i, counts wrong words as they
// are sent, remembers the first one, and counts the clock edges between the
// accepted start and the last word.
// ----------------------------------------------------------------------------
module tb_ddr3_read_checker;

  localparam logic [127:0] BASE = 128'hdeadbeefabad1deaba53b411fadebabe;
  localparam logic [31:0]  NONE = 32'hffffffff;

  logic         clk;
  logic         reset;
  logic         start;
  logic [31:0]  num_words;
  logic [127:0] rd_data;
  logic         rd_data_valid;
  logic         busy;
  logic         done;
  logic         pass;
  logic [31:0]  error_count;
  logic [31:0]  first_error_index;
  logic [127:0] first_error_data;
  logic [63:0]  cycles;

  int checkCount;
  int errorCount;

  // Reference model state for the current run.
  logic [31:0]  mdlErr;
  logic [31:0]  mdlFirstIdx;
  logic [127:0] mdlFirstData;
  logic [63:0]  mdlCycles;

  ddr3_read_checker #(.DATA_BASE(BASE)) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .num_words         (num_words),
    .rd_data           (rd_data),
    .rd_data_valid     (rd_data_valid),
    .busy              (busy),
    .done              (done),
    .pass              (pass),
    .error_count       (error_count),
    .first_error_index (first_error_index),
    .first_error_data  (first_error_data),
    .cycles            (cycles)
  );

  // 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] randWord();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Compare every result output against the model.
  task automatic checkResults(input string tag, input logic expDone);
    checkOutput({tag, "_done"}, {127'd0, done}, {127'd0, expDone});
    checkOutput({tag, "_busy"}, {127'd0, busy}, {127'd0, !expDone});
    checkOutput({tag, "_pass"}, {127'd0, pass}, {127'd0, (mdlErr == 32'd0)});
    checkOutput({tag, "_errcnt"}, {96'd0, error_count}, {96'd0, mdlErr});
    checkOutput({tag, "_firstidx"}, {96'd0, first_error_index}, {96'd0, mdlFirstIdx});
    checkOutput({tag, "_firstdata"}, first_error_data, mdlFirstData);
    checkOutput({tag, "_cycles"}, {64'd0, cycles}, {64'd0, mdlCycles});
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, {127'd0, busy}, 128'd0);
    checkOutput({tag, "_done"}, {127'd0, done}, 128'd0);
    checkOutput({tag, "_pass"}, {127'd0, pass}, 128'd0);
    checkOutput({tag, "_errcnt"}, {96'd0, error_count}, 128'd0);
    checkOutput({tag, "_firstidx"}, {96'd0, first_error_index}, 128'd0);
    checkOutput({tag, "_firstdata"}, first_error_data, 128'd0);
    checkOutput({tag, "_cycles"}, {64'd0, cycles}, 128'd0);
  endtask

  // Send one complete run. Words at forceA/forceB are sent as zero, others
  // are corrupted with probability errPct percent. A random valid rides
  // along with the start pulse and stray start pulses appear mid-run; both
  // must be ignored. Ends with the outputs sampled one cycle after the last
  // valid and compared against the model.
  task automatic applyStimulus(input string tag, input logic [31:0] num,
                               input int maxGap, input int errPct,
                               input logic [31:0] forceA, input logic [31:0] forceB);
    logic [127:0] want;
    logic [127:0] word;
    int           gap;
    start         = 1'b1;
    num_words     = num;
    rd_data_valid = 1'($urandom_range(0, 1));
    rd_data       = randWord();
    tick();
    start         = 1'b0;
    rd_data_valid = 1'b0;
    mdlErr        = 32'd0;
    mdlFirstIdx   = 32'd0;
    mdlFirstData  = 128'd0;
    mdlCycles     = 64'd0;
    if (num != 32'd0) begin
      checkOutput({tag, "_busy_after_start"}, {127'd0, busy}, 128'd1);
      for (int i = 0; i < int'(num); i++) begin
        gap = $urandom_range(0, maxGap);
        for (int g = 0; g < gap; g++) begin
          rd_data_valid = 1'b0;
          rd_data       = randWord();
          start         = ($urandom_range(0, 3) == 0);
          num_words     = $urandom;
          tick();
          mdlCycles++;
        end
        want = BASE + 128'(i);
        if (32'(i) == forceA || 32'(i) == forceB) begin
          word = 128'd0;
        end else if (int'($urandom_range(0, 99)) < errPct) begin
          word = want ^ (128'd1 << $urandom_range(0, 127));
        end else begin
          word = want;
        end
        start         = ($urandom_range(0, 3) == 0);
        rd_data       = word;
        rd_data_valid = 1'b1;
        tick();
        mdlCycles++;
        if (word != want) begin
          if (mdlErr == 32'd0) begin
            mdlFirstIdx  = 32'(i);
            mdlFirstData = word;
          end
          mdlErr++;
        end
      end
    end
    start         = 1'b0;
    rd_data_valid = 1'b0;
    checkResults(tag, 1'b1);
  endtask

  // Stray valids after a run must leave every result untouched.
  task automatic strayData(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      rd_data       = randWord();
      rd_data_valid = 1'b1;
      tick();
    end
    rd_data_valid = 1'b0;
    tick();
    checkResults(tag, 1'b1);
  endtask

  initial begin
    checkCount    = 0;
    errorCount    = 0;
    reset         = 1'b1;
    start         = 1'b0;
    num_words     = 32'd0;
    rd_data       = 128'd0;
    rd_data_valid = 1'b0;
    tick();
    tick();
    checkAllZero("reset");
    reset = 1'b0;
    tick();

    // Clean run, consecutive valids.
    applyStimulus("clean4", 32'd4, 0, 0, NONE, NONE);
    // Single zeroed word at index 5.
    applyStimulus("single_err", 32'd8, 0, 0, 32'd5, NONE);
    // Gaps between valids, two zeroed words.
    applyStimulus("gaps_err", 32'd6, 3, 0, 32'd1, 32'd4);
    // Zero-length run followed by stray data.
    applyStimulus("zero_len", 32'd0, 0, 0, NONE, NONE);
    strayData("zero_stray", 4);
    strayData("gaps_stray_pre", 0);

    // Back-to-back randomized runs, each started from DONE.
    for (int r = 0; r < 12; r++) begin
      applyStimulus($sformatf("rand%0d", r), 32'($urandom_range(1, 24)),
                    3, 25, NONE, NONE);
      if (r % 4 == 3) strayData($sformatf("rand%0d_stray", r), 3);
    end

    // Maximum-length run abandoned by reset mid-CHECK.
    start     = 1'b1;
    num_words = 32'hffffffff;
    tick();
    start = 1'b0;
    checkOutput("maxlen_busy", {127'd0, busy}, 128'd1);
    for (int k = 0; k < 5; k++) begin
      rd_data       = (k == 2) ? 128'd0 : BASE + 128'(k);
      rd_data_valid = 1'b1;
      tick();
    end
    rd_data_valid = 1'b0;
    checkOutput("maxlen_errcnt", {96'd0, error_count}, 128'd1);
    checkOutput("maxlen_not_done", {127'd0, done}, 128'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkAllZero("mid_reset");
    tick();
    checkAllZero("mid_reset_hold");

    // Normal operation after the abandoned run.
    applyStimulus("post_reset", 32'd10, 2, 30, 32'd0, NONE);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule : tb_ddr3_read_checker
